done_sequencer: RTL and testbench
=================================

# done_sequencer

Launches one hardware task per Nios start command and produces the level-sensitive completion flag sampled by the 1-bit "done" input PIO. The block takes a start level from a Nios output PIO, issues a single-cycle go pulse to the worker, waits for the worker's finish pulse, and holds `done_out` high until the next start. It also exports an elapsed-cycle count for a second input PIO.

## Interface
Parameters:
- `CNT_W`, default 32: elapsed counter width.
- `TIMEOUT_CYCLES`, default 1000000: watchdog limit in cycles. Used only with the macro.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start_in` in 1: start level from the Nios output PIO. Only a rising edge is acted on.
- `worker_finish` in 1: single-cycle completion pulse from the worker.
- `worker_go` out 1: single-cycle launch pulse to the worker.
- `done_out` out 1: completion level, wired to the done PIO `in_port`.
- `elapsed` out CNT_W: cycle count of the last or current task.
- `timed_out` out 1: watchdog fired. Present only with the macro.

## Operation
- Reset values: state IDLE, `start_q`=0, `worker_go`=0, `done_out`=0, `elapsed`=0, `timed_out`=0.
- Edge detect: `start_q` registers `start_in` every cycle. `start_edge` = `start_in & ~start_q`.
- IDLE:
  - On `start_edge`, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - `worker_go`=1, `done_out`=0, `elapsed`=0, `timed_out`=0.
  - Always goes to RUN.
- RUN:
  - `elapsed` increments every cycle and saturates at all-ones.
  - On `worker_finish`, go to DONE.
- DONE:
  - `done_out`=1 and `elapsed` is frozen.
  - On `start_edge`, go to LAUNCH.
- Ignored events:
  - `start_edge` in LAUNCH or RUN. It is not queued.
  - `worker_finish` in IDLE, LAUNCH or DONE.
- A start level held high across task completion does not relaunch. A new 0→1 transition is required.
- Reset asserted mid-task returns the block to IDLE with reset values on the next edge. A worker already launched receives no cancel; its later finish pulse is ignored in IDLE.

## Timing
- Edge at cycle N: `start_in`=1 sampled with `start_q`=0.
  - Cycle N+1: state LAUNCH, `worker_go`=1, `done_out` falls to 0.
  - Cycle N+2: RUN.
- Finish at cycle N+1+k (k≥1): `worker_finish` sampled high in RUN.
  - `done_out`=1 from cycle N+2+k.
  - `elapsed`=k, the number of cycles from the go cycle to the finish cycle.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- Macro `DONE_SEQ_TIMEOUT_EN`.
- Defined:
  - `timed_out` port exists.
  - In RUN, when `elapsed` == `TIMEOUT_CYCLES` and `worker_finish`=0, go to DONE with `timed_out`=1.
  - Finish and timeout in the same cycle: finish wins, `timed_out`=0.
  - `timed_out` clears in LAUNCH.
- Undefined:
  - No port and no comparator.
  - RUN waits indefinitely. `elapsed` saturates.

## Structure
- Shared package `done_seq_pkg` holds:
  - State enum `done_seq_state_t` (IDLE, LAUNCH, RUN, DONE).
  - `DONE_SEQ_CNT_W_DEF`.
  - `DONE_SEQ_TIMEOUT_DEF`.
- One sub-module, `rise_detect`: a registered-input rising-edge detector with synchronous active-high reset. It is reusable for the other PIO-driven strobes.
- The state register, counter and output registers live in the top module.

## Test plan
- Reset, then a start rise at cycle 10 and finish at cycle 15:
  - `worker_go`=1 only in cycle 11.
  - `done_out`=1 from cycle 16.
  - `elapsed`=4.
- `start_in` held high after completion for 50 cycles: no second `worker_go`, `done_out` stays 1. Then drop for 1 cycle and raise: exactly one new `worker_go`, `done_out`→0.
- Extra start rise during RUN, plus a spurious `worker_finish` in IDLE: no extra `worker_go`, state unaffected, finish still completes normally.
- `reset` asserted 3 cycles into RUN: the next cycle shows `done_out`=0 and `elapsed`=0. A later finish pulse produces no change.
- `DONE_SEQ_TIMEOUT_EN` with `TIMEOUT_CYCLES`=20 and no finish: `done_out`=1, `timed_out`=1, `elapsed`=20.
- `DONE_SEQ_TIMEOUT_EN` with finish arriving in the same cycle the count reaches 20: `timed_out`=0.
- `CNT_W`=4 with finish after 40 cycles: `elapsed`=15, saturated.

Source files
------------

// File: rtl/done_seq_pkg.sv
// Shared state encoding and parameter defaults for the done_sequencer slice.
// The ST_* constants keep the legacy numeric encoding visible to older tooling.
package done_seq_pkg;

  localparam int DONE_SEQ_CNT_W_DEF   = 32;
  localparam int DONE_SEQ_TIMEOUT_DEF = 1000000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LAUNCH = ST_LAUNCH,
    RUN    = ST_RUN,
    DONE   = ST_DONE
  } done_seq_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered-input rising-edge detector for PIO-driven level strobes.
// Latency: rise is valid in the same cycle the level first samples high; no backpressure.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/done_sequencer.sv
// One worker task per Nios start rise; go pulse 1 cycle after the rise, done level 1 cycle after finish.
// No backpressure: extra starts while busy are dropped. Watchdog built only with DONE_SEQ_TIMEOUT_EN.
module done_sequencer
  import done_seq_pkg::*;
#(
  parameter int CNT_W          = DONE_SEQ_CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = DONE_SEQ_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic             worker_finish,
  output logic             worker_go,
  output logic             done_out,
`ifdef DONE_SEQ_TIMEOUT_EN
  output logic             timed_out,
`endif
  output logic [CNT_W-1:0] elapsed
);

  done_seq_state_t  state;
  logic             start_edge;
  logic [CNT_W-1:0] elapsed_inc;

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .level (start_in),
    .rise  (start_edge)
  );

  // Saturate rather than wrap so a hung worker never reads back as a short task.
  assign elapsed_inc = (elapsed == {CNT_W{1'b1}}) ? elapsed : elapsed + CNT_W'(1);

`ifdef DONE_SEQ_TIMEOUT_EN
  localparam logic [63:0] TIMEOUT_LIM = 64'(TIMEOUT_CYCLES);
  logic timeout_hit;
  assign timeout_hit = (64'(elapsed) == TIMEOUT_LIM);
`else
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      worker_go <= 1'b0;
      done_out  <= 1'b0;
      elapsed   <= '0;
`ifdef DONE_SEQ_TIMEOUT_EN
      timed_out <= 1'b0;
`endif
    end else begin
      worker_go <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state     <= LAUNCH;
            worker_go <= 1'b1;
            done_out  <= 1'b0;
            elapsed   <= '0;
`ifdef DONE_SEQ_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
          end
        end
        LAUNCH: begin
          state <= RUN;
        end
        RUN: begin
          // A finish in the same cycle as the limit still counts as a normal completion.
          if (worker_finish) begin
            state    <= DONE;
            done_out <= 1'b1;
            elapsed  <= elapsed_inc;
          end
`ifdef DONE_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            state     <= DONE;
            done_out  <= 1'b1;
            timed_out <= 1'b1;
          end
`endif
          else begin
            elapsed <= elapsed_inc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_done_sequencer.sv
// Bench for done_sequencer: directed scenarios plus random start/finish traffic against a timestamp model.
module tb_done_sequencer;

  localparam int TO = 20;

  logic        clk           = 1'b0;
  logic        reset         = 1'b1;
  logic        start_in      = 1'b0;
  logic        worker_finish = 1'b0;
  logic        go, done;
  logic [31:0] el;

  logic        start4 = 1'b0;
  logic        fin4   = 1'b0;
  logic        go4, done4;
  logic [3:0]  el4;
`ifdef DONE_SEQ_TIMEOUT_EN
  logic        to, to4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  done_sequencer #(.CNT_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_in      (start_in),
    .worker_finish (worker_finish),
    .worker_go     (go),
    .done_out      (done),
`ifdef DONE_SEQ_TIMEOUT_EN
    .timed_out     (to),
`endif
    .elapsed       (el)
  );

  done_sequencer #(.CNT_W(4), .TIMEOUT_CYCLES(1000)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .start_in      (start4),
    .worker_finish (fin4),
    .worker_go     (go4),
    .done_out      (done4),
`ifdef DONE_SEQ_TIMEOUT_EN
    .timed_out     (to4),
`endif
    .elapsed       (el4)
  );

  // Reference model: a task is a go timestamp; elapsed is derived from edge counts.
  int          edge_n  = 0;
  int          go_edge = 0;
  bit          m_prev = 1'b0, m_launch = 1'b0, m_run = 1'b0, m_done = 1'b0, m_to = 1'b0;
  logic [31:0] m_el_hold = 32'd0;
  logic        exp_go = 1'b0, exp_done = 1'b0, exp_to = 1'b0;
  logic [31:0] exp_el = 32'd0;

  always @(posedge clk) begin
    bit rise;
    edge_n++;
    if (reset) begin
      m_prev = 1'b0; m_launch = 1'b0; m_run = 1'b0; m_done = 1'b0; m_to = 1'b0;
      m_el_hold = 32'd0;
    end else begin
      rise   = start_in && !m_prev;
      m_prev = start_in;
      if (m_launch) begin
        m_launch = 1'b0;
        m_run    = 1'b1;
      end else if (m_run) begin
        if (worker_finish) begin
          m_run = 1'b0; m_done = 1'b1;
          m_el_hold = 32'(edge_n - go_edge - 1);
        end
`ifdef DONE_SEQ_TIMEOUT_EN
        else if (edge_n - go_edge - 2 == TO) begin
          m_run = 1'b0; m_done = 1'b1; m_to = 1'b1;
          m_el_hold = 32'(TO);
        end
`endif
      end else if (rise) begin
        m_launch = 1'b1; go_edge = edge_n;
        m_done = 1'b0; m_to = 1'b0; m_el_hold = 32'd0;
      end
    end
    exp_go   = m_launch;
    exp_done = m_done;
    exp_to   = m_to;
    exp_el   = m_run ? 32'(edge_n - go_edge - 1) : m_el_hold;
  end

  task automatic test_reset();
    reset = 1'b1; start_in = 1'b0; worker_finish = 1'b0; start4 = 1'b0; fin4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (go !== 1'b0 || done !== 1'b0 || el !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: go=%b done=%b elapsed=%0d, expected 0 0 0", go, done, el);
    end
    checks++;
    if (go4 !== 1'b0 || done4 !== 1'b0 || el4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state_w4: go=%b done=%b elapsed=%0d, expected 0 0 0", go4, done4, el4);
    end
`ifdef DONE_SEQ_TIMEOUT_EN
    checks++;
    if (to !== 1'b0 || to4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_timed_out: got %b/%b, expected 0/0", to, to4);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    start_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      worker_finish = 1'b0;
      checks++;
      if (go !== exp_go || done !== exp_done || el !== exp_el) begin
        errors++;
        $display("FAIL basic_model: cycle +%0d go=%b done=%b elapsed=%0d, expected %b %b %0d",
                 i, go, done, el, exp_go, exp_done, exp_el);
      end
      checks++;
      if (go !== (i == 1) || done !== (i >= 6)) begin
        errors++;
        $display("FAIL basic_timing: cycle +%0d go=%b done=%b, expected %b %b", i, go, done, i == 1, i >= 6);
      end
      if (i == 5) worker_finish = 1'b1;
    end
    checks++;
    if (el !== 32'd4) begin
      errors++;
      $display("FAIL basic_elapsed: got %0d, expected 4", el);
    end
  endtask

  task automatic test_hold_high();
    int gos;
    bit dropped;
    gos = 0; dropped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (go === 1'b1) gos++;
      if (done !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (gos != 0 || dropped) begin
      errors++;
      $display("FAIL hold_no_relaunch: go pulses=%0d done_dropped=%b, expected 0 0", gos, dropped);
    end
    start_in = 1'b0;
    @(negedge clk);
    start_in = 1'b1;
    gos = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (go === 1'b1) gos++;
      checks++;
      if (go !== exp_go || done !== exp_done || el !== exp_el) begin
        errors++;
        $display("FAIL relaunch_model: cycle +%0d go=%b done=%b elapsed=%0d, expected %b %b %0d",
                 i, go, done, el, exp_go, exp_done, exp_el);
      end
    end
    checks++;
    if (gos != 1 || done !== 1'b0) begin
      errors++;
      $display("FAIL relaunch: go pulses=%0d done=%b, expected 1 0", gos, done);
    end
    worker_finish = 1'b1;
    @(negedge clk);
    worker_finish = 1'b0;
    checks++;
    if (done !== 1'b1 || el !== 32'd3) begin
      errors++;
      $display("FAIL relaunch_done: done=%b elapsed=%0d, expected 1 3", done, el);
    end
  endtask

  task automatic test_ignored();
    int gos;
    gos = 0;
    reset = 1'b1; start_in = 1'b0; worker_finish = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    worker_finish = 1'b1;
    @(negedge clk);
    worker_finish = 1'b0;
    checks++;
    if (go !== 1'b0 || done !== 1'b0 || el !== 32'd0) begin
      errors++;
      $display("FAIL spurious_finish: go=%b done=%b elapsed=%0d, expected 0 0 0", go, done, el);
    end
    start_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (go === 1'b1) gos++;
      checks++;
      if (go !== exp_go || done !== exp_done || el !== exp_el) begin
        errors++;
        $display("FAIL ignored_model: cycle +%0d go=%b done=%b elapsed=%0d, expected %b %b %0d",
                 i, go, done, el, exp_go, exp_done, exp_el);
      end
      if (i == 3) start_in = 1'b0;
      if (i == 4) start_in = 1'b1;
      worker_finish = (i == 8);
    end
    checks++;
    if (gos != 1 || done !== 1'b1 || el !== 32'd7) begin
      errors++;
      $display("FAIL ignored_start: go pulses=%0d done=%b elapsed=%0d, expected 1 1 7", gos, done, el);
    end
  endtask

  task automatic test_reset_mid();
    start_in = 1'b0;
    @(negedge clk);
    start_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1; start_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (go !== 1'b0 || done !== 1'b0 || el !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: go=%b done=%b elapsed=%0d, expected 0 0 0", go, done, el);
    end
    worker_finish = 1'b1;
    @(negedge clk);
    worker_finish = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (go !== 1'b0 || done !== 1'b0 || el !== 32'd0) begin
        errors++;
        $display("FAIL late_finish: go=%b done=%b elapsed=%0d, expected 0 0 0", go, done, el);
      end
    end
  endtask

  task automatic test_saturate();
    start4 = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 30) begin
        checks++;
        if (el4 !== 4'd15 || done4 !== 1'b0) begin
          errors++;
          $display("FAIL sat_running: elapsed=%0d done=%b, expected 15 0", el4, done4);
        end
      end
      fin4 = (i == 41);
    end
    checks++;
    if (el4 !== 4'd15 || done4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_done: elapsed=%0d done=%b, expected 15 1", el4, done4);
    end
  endtask

`ifdef DONE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    reset = 1'b1; start_in = 1'b0; worker_finish = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    start_in = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 60);
    checks++;
    if (n != 23 || done !== 1'b1 || to !== 1'b1 || el !== 32'(TO)) begin
      errors++;
      $display("FAIL timeout_fire: cycles=%0d done=%b timed_out=%b elapsed=%0d, expected 23 1 1 %0d",
               n, done, to, el, TO);
    end
    start_in = 1'b0;
    @(negedge clk);
    start_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_el == 32'(TO) && !exp_done) && n < 60);
    worker_finish = 1'b1;
    @(negedge clk);
    worker_finish = 1'b0;
    checks++;
    if (done !== 1'b1 || to !== 1'b0 || el !== 32'(TO + 1)) begin
      errors++;
      $display("FAIL timeout_race: done=%b timed_out=%b elapsed=%0d, expected 1 0 %0d", done, to, el, TO + 1);
    end
  endtask
`endif

  task automatic test_random();
    reset = 1'b1; start_in = 1'b0; worker_finish = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (go !== exp_go || done !== exp_done || el !== exp_el) begin
        errors++;
        $display("FAIL random_model: step %0d go=%b done=%b elapsed=%0d, expected %b %b %0d",
                 c, go, done, el, exp_go, exp_done, exp_el);
      end
`ifdef DONE_SEQ_TIMEOUT_EN
      checks++;
      if (to !== exp_to) begin
        errors++;
        $display("FAIL random_timed_out: step %0d got %b, expected %b", c, to, exp_to);
      end
`endif
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) start_in = ~start_in;
      worker_finish = ($urandom_range(0, 9) == 0);
    end
    reset = 1'b0;
    worker_finish = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_high();
    test_ignored();
    test_reset_mid();
    test_saturate();
`ifdef DONE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

endmodule
